// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encodings, ray direction tables, FSM states, address packing.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Direction order N, NE, E, SE, S, SW, W, NW; N is y-1, E is x+1 (4-bit two's complement)
    localparam logic [3:0] DX [8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF};
    localparam logic [3:0] DY [8] = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'hF};

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        TGT_RD    = 4'd1,
        DIR_INIT  = 4'd2,
        STEP_RD   = 4'd3,
        STEP_EVAL = 4'd4,
        FLIP      = 4'd5,
        NEXT_DIR  = 4'd6,
        PLACE     = 4'd7,
        ACK       = 4'd8,
        REJECT    = 4'd9,
        REJ_WAIT  = 4'd10
    } state_t;

    // Board RAM address is row-major: {y, x}
    function automatic logic [5:0] board_addr(input logic [2:0] x, input logic [2:0] y);
        return {y, x};
    endfunction

    // Encoding 11 is not a legal disc and counts as an empty square
    function automatic logic cell_is_empty(input logic [1:0] c);
        return (c == CELL_EMPTY) || (c == 2'b11);
    endfunction

endpackage

// File: rtl/ray_stepper.sv
// Advances a board cursor one cell along a ray and flags when it leaves the 8x8 board.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module ray_stepper
    import othello_pkg::*;
(
    input  logic [3:0] cur_x,
    input  logic [3:0] cur_y,
    input  logic [2:0] dir,
    output logic [3:0] nxt_x,
    output logic [3:0] nxt_y,
    output logic       off_board
);

    // Cursor is always on-board, so a step lands in -1..8; both ends set bit 3
    always_comb begin
        nxt_x     = cur_x + DX[dir];
        nxt_y     = cur_y + DY[dir];
        off_board = nxt_x[3] | nxt_y[3];
    end

endmodule

// File: rtl/move_validator.sv
// Validates an Othello move, flips captured discs along all 8 rays, places the disc, then acks.
// Latency: target read plus one ray scan per direction; at most ~160 cycles with RD_LAT = 1.
// Backpressure: new_move/go are ignored while busy; an illegal move waits in REJ_WAIT for go.
module move_validator
    import othello_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int FLIP_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              new_move,
    input  logic              player,
    input  logic              go,
    input  logic [2:0]        move_x,
    input  logic [2:0]        move_y,
    output logic [5:0]        rd_addr,
    input  logic [1:0]        rd_data,
    output logic              wr_en,
    output logic [5:0]        wr_addr,
    output logic [1:0]        wr_data,
    output logic              ack,
    output logic              reject,
    output logic              busy,
    output logic [FLIP_W-1:0] flip_count
);

    localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    state_t            state, state_nxt;
    logic              new_move_q, go_q;
    logic              ply;
    logic [2:0]        tx, ty;
    logic [2:0]        dir;
    logic [2:0]        run;
    logic [2:0]        flip_idx;
    logic [FLIP_W-1:0] total;
    logic [LAT_W-1:0]  lat_cnt;
    logic [3:0]        cur_x, cur_y;
    logic [3:0]        flip_x, flip_y;
    logic [3:0]        step_in_x, step_in_y;
    logic [3:0]        step_nx, step_ny;
    logic              step_off;

    logic       nm_rise, go_fall, submit, lat_done;
    logic [1:0] own_col, opp_col;
    logic       cell_own, cell_opp, cell_empty;

    assign nm_rise    = new_move & ~new_move_q;
    assign go_fall    = ~go & go_q;
    assign submit     = ((state == IDLE) && nm_rise) ||
                        ((state == REJ_WAIT) && new_move && go_fall);
    assign lat_done   = (lat_cnt == LAT_W'(RD_LAT));
    assign own_col    = ply ? CELL_WHITE : CELL_BLACK;
    assign opp_col    = ply ? CELL_BLACK : CELL_WHITE;
    assign cell_own   = (rd_data == own_col);
    assign cell_opp   = (rd_data == opp_col);
    assign cell_empty = cell_is_empty(rd_data);

    // One stepper serves both the scan cursor and the flip cursor; they never run together
    assign step_in_x = (state == FLIP) ? flip_x : cur_x;
    assign step_in_y = (state == FLIP) ? flip_y : cur_y;

    ray_stepper u_stepper (
        .cur_x     (step_in_x),
        .cur_y     (step_in_y),
        .dir       (dir),
        .nxt_x     (step_nx),
        .nxt_y     (step_ny),
        .off_board (step_off)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = 6'd0;
        wr_data   = CELL_EMPTY;
        ack       = 1'b0;
        reject    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (nm_rise) state_nxt = TGT_RD;
            end
            TGT_RD: begin
                if (lat_done) state_nxt = cell_empty ? DIR_INIT : REJECT;
            end
            DIR_INIT: state_nxt = STEP_RD;
            STEP_RD: state_nxt = step_off ? NEXT_DIR : STEP_EVAL;
            STEP_EVAL: begin
                if (lat_done) begin
                    if (cell_opp)                    state_nxt = STEP_RD;
                    else if (cell_own && run != 3'd0) state_nxt = FLIP;
                    else                             state_nxt = NEXT_DIR;
                end
            end
            FLIP: begin
                wr_en   = 1'b1;
                wr_addr = board_addr(step_nx[2:0], step_ny[2:0]);
                wr_data = own_col;
                if ((flip_idx + 3'd1) == run) state_nxt = NEXT_DIR;
            end
            NEXT_DIR: begin
                if (dir == 3'd7) state_nxt = (total != '0) ? PLACE : REJECT;
                else             state_nxt = DIR_INIT;
            end
            PLACE: begin
                wr_en     = 1'b1;
                wr_addr   = board_addr(tx, ty);
                wr_data   = own_col;
                state_nxt = ACK;
            end
            ACK: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            REJECT: begin
                reject    = 1'b1;
                state_nxt = REJ_WAIT;
            end
            REJ_WAIT: begin
                busy = 1'b0;
                if (!new_move)    state_nxt = IDLE;
                else if (go_fall) state_nxt = TGT_RD;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: edge detectors, latched move, cursors, counters, read address, result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            new_move_q <= 1'b0;
            go_q       <= 1'b0;
            ply        <= 1'b0;
            tx         <= 3'd0;
            ty         <= 3'd0;
            dir        <= 3'd0;
            run        <= 3'd0;
            flip_idx   <= 3'd0;
            total      <= '0;
            lat_cnt    <= '0;
            cur_x      <= 4'd0;
            cur_y      <= 4'd0;
            flip_x     <= 4'd0;
            flip_y     <= 4'd0;
            rd_addr    <= 6'd0;
            flip_count <= '0;
        end else begin
            new_move_q <= new_move;
            go_q       <= go;

            // Only the two read-wait states count; everything else parks at zero
            if ((state == TGT_RD || state == STEP_EVAL) && state_nxt == state)
                lat_cnt <= lat_cnt + LAT_W'(1);
            else
                lat_cnt <= '0;

            if (submit) begin
                ply     <= player;
                tx      <= move_x;
                ty      <= move_y;
                rd_addr <= board_addr(move_x, move_y);
            end

            case (state)
                TGT_RD: begin
                    dir   <= 3'd0;
                    total <= '0;
                end
                DIR_INIT: begin
                    cur_x    <= {1'b0, tx};
                    cur_y    <= {1'b0, ty};
                    flip_x   <= {1'b0, tx};
                    flip_y   <= {1'b0, ty};
                    run      <= 3'd0;
                    flip_idx <= 3'd0;
                end
                STEP_RD: begin
                    if (!step_off) begin
                        cur_x   <= step_nx;
                        cur_y   <= step_ny;
                        rd_addr <= board_addr(step_nx[2:0], step_ny[2:0]);
                    end
                end
                STEP_EVAL: begin
                    if (lat_done && cell_opp) run <= run + 3'd1;
                    if (lat_done && cell_own && run != 3'd0)
                        total <= total + FLIP_W'(run);
                end
                FLIP: begin
                    flip_x   <= step_nx;
                    flip_y   <= step_ny;
                    flip_idx <= flip_idx + 3'd1;
                end
                NEXT_DIR: dir <= dir + 3'd1;
                ACK:      flip_count <= total;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_validator.sv
// Directed bench for move_validator with a behavioural 1-cycle-latency board RAM.
// Latency: RAM read data appears one clock after rd_addr.
// Backpressure: none; the bench plays the main controller.
module tb_move_validator;

    logic       clock;
    logic       reset;
    logic       new_move;
    logic       player;
    logic       go;
    logic [2:0] move_x;
    logic [2:0] move_y;
    logic [5:0] rd_addr;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       ack;
    logic       reject;
    logic       busy;
    logic [4:0] flip_count;

    logic [1:0] board  [64];
    logic [1:0] preset [64];
    logic       load;
    logic [7:0] wlog [$];
    int         ack_cnt;
    int         rej_cnt;
    int         both_cnt;
    int         checks;
    int         fails;

    move_validator #(.RD_LAT(1), .FLIP_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .new_move   (new_move),
        .player     (player),
        .go         (go),
        .move_x     (move_x),
        .move_y     (move_y),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ack        (ack),
        .reject     (reject),
        .busy       (busy),
        .flip_count (flip_count)
    );

    always #5 clock = ~clock;

    // Board RAM model plus write/pulse logging
    always @(posedge clock) begin
        rd_data <= board[rd_addr];
        if (load) board <= preset;
        else if (wr_en) board[wr_addr] <= wr_data;
        if (wr_en) wlog.push_back({wr_addr, wr_data});
        if (ack) ack_cnt++;
        if (reject) rej_cnt++;
        if (ack && reject) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wl(input int i);
        return (wlog.size() > i) ? wlog[i] : 8'hFF;
    endfunction

    task automatic load_board(input int kind);
        for (int i = 0; i < 64; i++) preset[i] = 2'b00;
        if (kind == 0) begin
            preset[27] = 2'b10; preset[36] = 2'b10;
            preset[28] = 2'b01; preset[35] = 2'b01;
        end else begin
            preset[1] = 2'b10; preset[2] = 2'b10; preset[3] = 2'b10; preset[4] = 2'b01;
            preset[8] = 2'b10; preset[16] = 2'b10; preset[24] = 2'b01;
        end
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wlog.delete();
    endtask

    task automatic do_move(input logic p, input logic [2:0] x, input logic [2:0] y);
        player   = p;
        move_x   = x;
        move_y   = y;
        new_move = 1'b1;
    endtask

    task automatic wait_done(output logic got_ack, output logic got_rej);
        got_ack = 1'b0;
        got_rej = 1'b0;
        for (int i = 0; i < 300 && !got_ack && !got_rej; i++) begin
            @(negedge clock);
            got_ack = ack;
            got_rej = reject;
        end
        if (!got_ack && !got_rej) chk("timeout", 0, 1);
    endtask

    initial begin
        logic a, r, seen;
        int   acks0, rej0;
        clock = 0; reset = 0; new_move = 0; player = 0; go = 0;
        move_x = 0; move_y = 0; load = 0;
        ack_cnt = 0; rej_cnt = 0; both_cnt = 0; checks = 0; fails = 0;
        for (int i = 0; i < 64; i++) preset[i] = 2'b00;

        repeat (2) @(negedge clock);
        chk("rst_ack", ack, 0);
        chk("rst_reject", reject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_flip_count", flip_count, 0);
        reset = 1;
        @(negedge clock);

        // 1: black at (3,2) captures 27 southwards
        load_board(0);
        do_move(0, 3'd3, 3'd2);
        wait_done(a, r);
        chk("t1_ack", a, 1);
        chk("t1_rej", r, 0);
        new_move = 0;
        @(negedge clock);
        chk("t1_nwr", wlog.size(), 2);
        chk("t1_w0", wl(0), {6'd27, 2'b01});
        chk("t1_w1", wl(1), {6'd19, 2'b01});
        chk("t1_flip_count", flip_count, 1);
        chk("t1_busy", busy, 0);

        // 2: occupied target rejects without writing
        load_board(0);
        rej0 = rej_cnt;
        do_move(0, 3'd3, 3'd3);
        wait_done(a, r);
        chk("t2_rej", r, 1);
        chk("t2_ack", a, 0);
        repeat (2) @(negedge clock);
        chk("t2_busy", busy, 0);
        chk("t2_nwr", wlog.size(), 0);
        chk("t2_rej_pulses", rej_cnt - rej0, 1);
        new_move = 0;
        repeat (2) @(negedge clock);

        // 3: white at corner captures nothing
        load_board(0);
        do_move(1, 3'd0, 3'd0);
        wait_done(a, r);
        chk("t3_rej", r, 1);
        @(negedge clock);
        chk("t3_nwr", wlog.size(), 0);
        chk("t3_flip_count_held", flip_count, 1);
        chk("t3_busy", busy, 0);

        // 5: resubmit via go falling edge, white at (4,2)
        wlog.delete();
        player = 1; move_x = 3'd4; move_y = 3'd2;
        go = 1;
        @(negedge clock);
        go = 0;
        wait_done(a, r);
        chk("t5_ack", a, 1);
        new_move = 0;
        @(negedge clock);
        chk("t5_nwr", wlog.size(), 2);
        chk("t5_w0", wl(0), {6'd28, 2'b10});
        chk("t5_w1", wl(1), {6'd20, 2'b10});

        // 4: black at (0,0) captures 3 east then 2 south
        load_board(1);
        do_move(0, 3'd0, 3'd0);
        wait_done(a, r);
        chk("t4_ack", a, 1);
        new_move = 0;
        @(negedge clock);
        chk("t4_nwr", wlog.size(), 6);
        chk("t4_w0", wl(0), {6'd1, 2'b01});
        chk("t4_w1", wl(1), {6'd2, 2'b01});
        chk("t4_w2", wl(2), {6'd3, 2'b01});
        chk("t4_w3", wl(3), {6'd8, 2'b01});
        chk("t4_w4", wl(4), {6'd16, 2'b01});
        chk("t4_w5", wl(5), {6'd0, 2'b01});
        chk("t4_flip_count", flip_count, 5);

        // 6: reset in the middle of FLIP
        load_board(1);
        acks0 = ack_cnt;
        do_move(0, 3'd0, 3'd0);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            seen = wr_en;
        end
        chk("t6_flip_seen", seen, 1);
        #1 reset = 0;
        new_move = 0;
        #1;
        chk("t6_wr_en", wr_en, 0);
        chk("t6_outs", {ack, reject, busy, wr_addr, wr_data}, 0);
        chk("t6_rd_addr", rd_addr, 0);
        chk("t6_flip_count", flip_count, 0);
        @(negedge clock);
        reset = 1;
        repeat (20) @(negedge clock);
        chk("t6_no_ack", ack_cnt - acks0, 0);
        chk("t6_idle_busy", busy, 0);
        chk("t6_nwr", wlog.size(), 0);
        load_board(1);
        do_move(0, 3'd0, 3'd0);
        wait_done(a, r);
        chk("t6_rerun_ack", a, 1);
        new_move = 0;
        @(negedge clock);
        chk("t6_rerun_flip_count", flip_count, 5);
        chk("ack_rej_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
